// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-file types and default sizes
package cpu_pkg;

  localparam int DEF_DATA_WIDTH = 64;
  localparam int DEF_REG_NUM    = 32;

  typedef logic [$clog2(DEF_REG_NUM)-1:0] reg_idx_t;

  typedef enum logic {
    RF_INIT,
    RF_READY
  } rf_state_e;

endpackage

// File: rtl/regfile_init_fsm.sv
// rtl/regfile_init_fsm.sv - post-reset sweep that clears every register entry once
module regfile_init_fsm
  import cpu_pkg::*;
#(
  parameter int REG_NUM = DEF_REG_NUM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic                       init_busy,
  output logic                       sweep_we,
  output logic [$clog2(REG_NUM)-1:0] sweep_idx
);

  localparam int AW = $clog2(REG_NUM);
  localparam logic [AW-1:0] LAST_IDX = AW'(REG_NUM - 1);

  rf_state_e state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RF_INIT;
      sweep_idx <= '0;
      init_busy <= 1'b1;
      sweep_we  <= 1'b1;
    end else begin
      case (state)
        RF_INIT: begin
          // The last entry is cleared on the same edge that leaves INIT.
          if (sweep_idx == LAST_IDX) begin
            state     <= RF_READY;
            init_busy <= 1'b0;
            sweep_we  <= 1'b0;
          end else begin
            sweep_idx <= sweep_idx + 1'b1;
          end
        end
        default: begin
          state     <= RF_READY;
          init_busy <= 1'b0;
          sweep_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// rtl/regfile_2r1w.sv - 2-read/1-write register file, x0 hardwired, optional RF_WR_BYPASS_EN write-through
module regfile_2r1w
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int REG_NUM    = DEF_REG_NUM
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rd_en,
  input  logic [$clog2(REG_NUM)-1:0] rs1_addr,
  input  logic [$clog2(REG_NUM)-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0]      rs1_data,
  output logic [DATA_WIDTH-1:0]      rs2_data,
  input  logic                       we,
  input  logic [$clog2(REG_NUM)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  output logic                       init_busy
);

  localparam int AW    = $clog2(REG_NUM);
  localparam int DEPTH = 1 << AW;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      idx_valid;
  logic                  sweep_we;
  logic [AW-1:0]         sweep_idx;
  logic [DATA_WIDTH-1:0] rd1_word;
  logic [DATA_WIDTH-1:0] rd2_word;

  regfile_init_fsm #(
    .REG_NUM (REG_NUM)
  ) u_init_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .sweep_we  (sweep_we),
    .sweep_idx (sweep_idx)
  );

  // Index 0 and indices past REG_NUM are neither writable nor readable.
  always_comb begin
    idx_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx_valid[i] = (i != 0) && (i < REG_NUM);
    end
  end

  always_ff @(posedge clk) begin
    if (sweep_we) begin
      mem[sweep_idx] <= '0;
    end else if (we && idx_valid[wr_addr]) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd1_word = idx_valid[rs1_addr] ? mem[rs1_addr] : '0;
    rd2_word = idx_valid[rs2_addr] ? mem[rs2_addr] : '0;
`ifdef RF_WR_BYPASS_EN
    if (we && idx_valid[wr_addr] && (wr_addr == rs1_addr)) begin
      rd1_word = wr_data;
    end
    if (we && idx_valid[wr_addr] && (wr_addr == rs2_addr)) begin
      rd2_word = wr_data;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (init_busy) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if (rd_en) begin
      rs1_data <= rd1_word;
      rs2_data <= rd2_word;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// tb/tb_regfile_2r1w.sv - table-driven scoreboard bench for regfile_2r1w
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        we;
  logic [4:0]  wr_addr;
  logic [63:0] wr_data;
  logic        init_busy;

  regfile_2r1w #(
    .DATA_WIDTH (64),
    .REG_NUM    (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rd_en),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .we        (we),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .init_busy (init_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        rd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [63:0] e1;
    logic [63:0] e2;
  } vec_t;

  typedef struct {
    logic [63:0] e1;
    logic [63:0] e2;
    string       nm;
  } exp_t;

  localparam logic [63:0] DEAD = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] TOPV = 64'h8000_0000_0000_0001;

  vec_t vecs [10];
  exp_t sb [$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      chk({e.nm, "_rs1"}, rs1_data, e.e1);
      chk({e.nm, "_rs2"}, rs2_data, e.e2);
    end
  endtask

  task automatic drive(input logic w, input logic [4:0] wa, input logic [63:0] wd,
                       input logic r, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [63:0] e1, input logic [63:0] e2, input string nm);
    we       = w;
    wr_addr  = wa;
    wr_data  = wd;
    rd_en    = r;
    rs1_addr = a1;
    rs2_addr = a2;
    sb.push_back('{e1, e2, nm});
    @(posedge clk);
    @(negedge clk);
    check_out();
  endtask

  task automatic wait_ready(input string nm);
    int cyc;
    int nonzero;
    cyc = 0;
    nonzero = 0;
    while (init_busy && cyc < 200) begin
      if (rs1_data !== 64'd0 || rs2_data !== 64'd0) nonzero++;
      cyc++;
      @(posedge clk);
      @(negedge clk);
    end
    we = 1'b0;
    chk({nm, "_busy_cycles"}, 64'(cyc), 64'd32);
    chk({nm, "_data_during_init"}, 64'(nonzero), 64'd0);
  endtask

  task automatic read_all_zero(input string nm);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'(i), 5'(31 - i), 64'd0, 64'd0, nm);
    end
  endtask

  initial begin
    vecs[0] = '{1'b1, 5'd5,  DEAD,          1'b1, 5'd1,  5'd2,  64'd0, 64'd0};
    vecs[1] = '{1'b0, 5'd0,  64'd0,         1'b1, 5'd5,  5'd5,  DEAD,  DEAD};
    vecs[2] = '{1'b1, 5'd0,  '1,            1'b1, 5'd5,  5'd0,  DEAD,  64'd0};
    vecs[3] = '{1'b0, 5'd0,  64'd0,         1'b1, 5'd0,  5'd0,  64'd0, 64'd0};
    vecs[4] = '{1'b1, 5'd7,  64'd1,         1'b1, 5'd3,  5'd4,  64'd0, 64'd0};
    vecs[5] = '{1'b1, 5'd31, TOPV,          1'b1, 5'd7,  5'd5,  64'd1, DEAD};
    vecs[6] = '{1'b1, 5'd12, 64'h55,        1'b1, 5'd31, 5'd0,  TOPV,  64'd0};
    vecs[7] = '{1'b0, 5'd0,  64'd0,         1'b1, 5'd12, 5'd12, 64'h55, 64'h55};
    vecs[8] = '{1'b0, 5'd0,  64'd0,         1'b0, 5'd3,  5'd31, 64'h55, 64'h55};
    vecs[9] = '{1'b1, 5'd1,  64'hAAAA,      1'b1, 5'd31, 5'd7,  TOPV,  64'd1};

    rst_n    = 1'b0;
    rd_en    = 1'b0;
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rs1_addr = '0;
    rs2_addr = '0;
    repeat (3) @(negedge clk);
    chk("reset_rs1", rs1_data, 64'd0);
    chk("reset_rs2", rs2_data, 64'd0);
    chk("reset_busy", 64'(init_busy), 64'd1);

    // First sweep, with writes and reads attempted while busy.
    rst_n    = 1'b1;
    rd_en    = 1'b1;
    we       = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = '1;
    rs1_addr = 5'd9;
    rs2_addr = 5'd9;
    wait_ready("init1");
    chk("ready_busy", 64'(init_busy), 64'd0);
    read_all_zero("init1_zero");

    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rd, vecs[i].a1, vecs[i].a2,
            vecs[i].e1, vecs[i].e2, $sformatf("vec%0d", i));
    end

    // Same-cycle write/read of reg 7 (holds 1).
`ifdef RF_WR_BYPASS_EN
    drive(1'b1, 5'd7, 64'd2, 1'b1, 5'd7, 5'd7, 64'd2, 64'd2, "hit_same_cycle");
`else
    drive(1'b1, 5'd7, 64'd2, 1'b1, 5'd7, 5'd7, 64'd1, 64'd1, "hit_same_cycle");
`endif
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 5'd7, 64'd2, 64'd2, "hit_after");

    // Stall: outputs hold while addresses change and the held index is written.
    drive(1'b0, 5'd0,  64'd0,  1'b1, 5'd7, 5'd12, 64'd2, 64'h55, "stall_pre");
    drive(1'b1, 5'd12, 64'h99, 1'b0, 5'd0, 5'd13, 64'd2, 64'h55, "stall1");
    drive(1'b1, 5'd13, 64'h77, 1'b0, 5'd0, 5'd12, 64'd2, 64'h55, "stall2");
    drive(1'b0, 5'd0,  64'd0,  1'b0, 5'd0, 5'd13, 64'd2, 64'h55, "stall3");
    drive(1'b0, 5'd0,  64'd0,  1'b1, 5'd13, 5'd12, 64'h77, 64'h99, "stall_release");

    // Reset mid-run clears outputs; then reset again at sweep counter 10.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_rs1", rs1_data, 64'd0);
    chk("midrun_rst_rs2", rs2_data, 64'd0);
    chk("midrun_rst_busy", 64'(init_busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    rd_en = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("sweep10_busy", 64'(init_busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midsweep_rst_busy", 64'(init_busy), 64'd1);
    chk("midsweep_rst_rs1", rs1_data, 64'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    we      = 1'b1;
    wr_addr = 5'd20;
    wr_data = 64'h1234_5678;
    wait_ready("init2");
    read_all_zero("init2_zero");

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
